// File: rtl/fetch_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared types and constants for the instruction fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam int          INSTR_BYTES = 4;
    // Bubble inserted by decode; fetch itself never emits it.
    localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// fetch_fifo : small {pc, instr} buffer between fetch and decode
// Revision   : 1.0
// ============================================================================
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic         clear_i,
    input  fetch_entry_t wdata_i,
    output fetch_entry_t rdata_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o,
    output logic         full_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Depth is a power of two, so pointers wrap naturally.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
// fetch_stage : PC register, single-outstanding imem reads, decode buffer
// Revision    : 1.0
// ============================================================================
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        id_valid,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   pc_inflight_q, pc_inflight_d;
    logic          issue, push, pop;
    logic          fifo_empty, fifo_full;
    logic [CW-1:0] fifo_count;
    fetch_entry_t  push_entry, head;
    logic          unused_pc_lsb;

    // Registered count only: no path from id_ready into imem_req.
    assign issue     = (state_q == RUN) && !redirect && (fifo_count < CW'(FIFO_DEPTH));
    assign imem_req  = issue;
    assign imem_addr = pc_q;

    assign id_valid  = !fifo_empty;
    assign id_instr  = id_valid ? head.instr : '0;
    assign id_pc     = id_valid ? head.pc    : '0;
    assign pop       = id_valid && id_ready;

    assign push_entry    = '{pc: pc_inflight_q, instr: imem_rdata};
    assign unused_pc_lsb = ^redirect_pc[1:0];

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        pc_inflight_d = pc_inflight_q;
        push          = 1'b0;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
            // An outstanding read must still be swallowed unless it lands now.
            if (state_q != RUN && !imem_rvalid) state_d = DRAIN;
            else                                state_d = RUN;
        end else begin
            case (state_q)
                RUN: begin
                    if (issue) begin
                        pc_inflight_d = pc_q;
                        pc_d          = pc_q + 32'(INSTR_BYTES);
                        state_d       = WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        push    = !fifo_full;
                        state_d = RUN;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = RUN;
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC;
            pc_inflight_q <= '0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            pc_inflight_q <= pc_inflight_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (redirect),
        .wdata_i (push_entry),
        .rdata_o (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
// tb_fetch_stage : self-checking bench for fetch_stage (model + directed tests)
// Revision       : 1.0
// ============================================================================
module tb_fetch_stage;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_ready    = 1'b0;
    logic        id_valid;
    logic [31:0] id_instr;
    logic [31:0] id_pc;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int lat      = 1;
    bit rand_lat = 1'b0;

    fetch_stage #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .id_ready    (id_ready),
        .id_valid    (id_valid),
        .id_instr    (id_instr),
        .id_pc       (id_pc)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0013;
    endfunction

    // Instruction memory: responses in request order after a per-request latency.
    logic [31:0] mq_addr [$];
    int          mq_due  [$];
    always @(negedge clk) begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (mq_due.size() > 0 && mq_due[0] <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(mq_addr[0]);
            void'(mq_addr.pop_front());
            void'(mq_due.pop_front());
        end
        if (imem_req && !rst) begin
            mq_addr.push_back(imem_addr);
            mq_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat));
        end
    end

    // Reference: decode sees consecutive PCs from the last reset/redirect target,
    // and requests walk the same sequence.
    logic [31:0] exp_pc, exp_req;
    bit          prev_redir;
    always @(negedge clk) begin
        if (rst) begin
            exp_pc     = RST_PC;
            exp_req    = RST_PC;
            prev_redir = 1'b0;
        end else begin
            if (prev_redir) begin
                checks++;
                if (id_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL mon_flush t=%0t id_valid=%b expected 0", $time, id_valid);
                end
            end
            if (imem_req) begin
                checks++;
                if (redirect || imem_addr !== exp_req) begin
                    failures++;
                    $display("FAIL mon_req t=%0t addr=%h redirect=%b expected addr=%h no redirect",
                             $time, imem_addr, redirect, exp_req);
                end
                exp_req = exp_req + 32'd4;
            end
            checks++;
            if (!id_valid) begin
                if (id_pc !== 32'd0 || id_instr !== 32'd0) begin
                    failures++;
                    $display("FAIL mon_idle t=%0t pc=%h instr=%h expected 0/0", $time, id_pc, id_instr);
                end
            end else if (id_pc !== exp_pc || id_instr !== mem_word(exp_pc)) begin
                failures++;
                $display("FAIL mon_head t=%0t pc=%h instr=%h expected pc=%h instr=%h",
                         $time, id_pc, id_instr, exp_pc, mem_word(exp_pc));
            end else if (id_ready && !redirect) begin
                exp_pc = exp_pc + 32'd4;
            end
            if (redirect) begin
                exp_pc  = redirect_pc & ~32'd3;
                exp_req = redirect_pc & ~32'd3;
            end
            prev_redir = redirect;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns at posedge+1 of the first cycle after reset release.
    task automatic reset_dut();
        tick();
        rst      = 1'b1;
        redirect = 1'b0;
        repeat (4) tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || id_pc !== 32'd0 || id_instr !== 32'd0) begin
            failures++;
            $display("FAIL reset_id valid=%b pc=%h instr=%h expected 0/0/0", id_valid, id_pc, id_instr);
        end
        checks++;
        if (imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL reset_addr addr=%h expected %h", imem_addr, RST_PC);
        end
    endtask

    task automatic test_fetch_seq();
        lat = 1; rand_lat = 1'b0; id_ready = 1'b1;
        reset_dut();
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'(c % 2 == 0) || (c % 2 == 0 && imem_addr !== 32'(c * 2))) begin
                failures++;
                $display("FAIL seq_req c=%0d req=%b addr=%h expected req=%b addr=%h",
                         c, imem_req, imem_addr, (c % 2 == 0), 32'(c * 2));
            end
            checks++;
            if (id_valid !== 1'(c >= 2 && c % 2 == 0) ||
                (c >= 2 && c % 2 == 0 && (id_pc !== 32'((c - 2) * 2) || id_instr !== mem_word(32'((c - 2) * 2))))) begin
                failures++;
                $display("FAIL seq_id c=%0d valid=%b pc=%h instr=%h expected pc=%h",
                         c, id_valid, id_pc, id_instr, 32'((c - 2) * 2));
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int  nreq  = 0;
        bit  found = 1'b0;
        lat = 1; rand_lat = 1'b0; id_ready = 1'b0;
        reset_dut();
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (imem_req) nreq++;
            if (c >= 4) begin
                checks++;
                if (imem_req !== 1'b0) begin
                    failures++;
                    $display("FAIL bp_full c=%0d req=%b expected 0", c, imem_req);
                end
            end
            if (c >= 2) begin
                checks++;
                if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
                    failures++;
                    $display("FAIL bp_head c=%0d valid=%b pc=%h expected 1/0", c, id_valid, id_pc);
                end
            end
            tick();
        end
        checks++;
        if (nreq != 2) begin
            failures++;
            $display("FAIL bp_count requests=%0d expected 2", nreq);
        end
        id_ready = 1'b1;
        for (int c = 0; c < 6 && !found; c++) begin
            @(negedge clk);
            if (imem_req) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found || imem_addr !== 32'h8) begin
            failures++;
            $display("FAIL bp_resume found=%b addr=%h expected 1/00000008", found, imem_addr);
        end
    endtask

    task automatic test_redirect_wait();
        bit found = 1'b0;
        lat = 3; rand_lat = 1'b0; id_ready = 1'b1;
        reset_dut();
        @(negedge clk);
        tick();
        redirect = 1'b1; redirect_pc = 32'h0000_0103;
        @(negedge clk);
        tick();
        redirect = 1'b0;
        for (int c = 2; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (imem_req !== 1'b0 || id_valid !== 1'b0) begin
                failures++;
                $display("FAIL rw_drain c=%0d req=%b valid=%b expected 0/0", c, imem_req, id_valid);
            end
            tick();
        end
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            failures++;
            $display("FAIL rw_newreq req=%b addr=%h expected 1/00000100", imem_req, imem_addr);
        end
        for (int k = 0; k < 10 && !found; k++) begin
            tick();
            @(negedge clk);
            if (id_valid) found = 1'b1;
        end
        checks++;
        if (!found || id_pc !== 32'h100 || id_instr !== mem_word(32'h100)) begin
            failures++;
            $display("FAIL rw_head found=%b pc=%h instr=%h expected pc=00000100", found, id_pc, id_instr);
        end
    endtask

    task automatic test_redirect_rvalid();
        lat = 1; rand_lat = 1'b0; id_ready = 1'b1;
        reset_dut();
        @(negedge clk);
        tick();
        redirect = 1'b1; redirect_pc = 32'h2000_0041;
        @(negedge clk);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h2000_0040) begin
            failures++;
            $display("FAIL rr_restart valid=%b req=%b addr=%h expected 0/1/20000040",
                     id_valid, imem_req, imem_addr);
        end
    endtask

    task automatic test_wrap();
        lat = 1; rand_lat = 1'b0; id_ready = 1'b1;
        reset_dut();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFE;
        @(negedge clk);
        tick();
        redirect = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_first req=%b addr=%h expected 1/fffffffc", imem_req, imem_addr);
        end
        tick(); tick();
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || id_pc !== 32'hFFFF_FFFC) begin
            failures++;
            $display("FAIL wrap_second req=%b addr=%h head=%h expected 1/00000000/fffffffc",
                     imem_req, imem_addr, id_pc);
        end
        tick(); tick();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
            failures++;
            $display("FAIL wrap_head valid=%b pc=%h expected 1/00000000", id_valid, id_pc);
        end
    endtask

    task automatic test_reset_midflight();
        lat = 3; rand_lat = 1'b0; id_ready = 1'b1;
        reset_dut();
        @(negedge clk);
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b0 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL rm_async valid=%b addr=%h expected 0/%h", id_valid, imem_addr, RST_PC);
        end
        tick();
        tick();
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (imem_req !== 1'b1 || imem_addr !== RST_PC) begin
            failures++;
            $display("FAIL rm_req req=%b addr=%h expected 1/%h", imem_req, imem_addr, RST_PC);
        end
        for (int c = 4; c < 7; c++) begin
            tick();
            @(negedge clk);
            checks++;
            if (id_valid !== 1'b0) begin
                failures++;
                $display("FAIL rm_stale c=%0d valid=%b expected 0", c, id_valid);
            end
        end
        tick();
        @(negedge clk);
        checks++;
        if (id_valid !== 1'b1 || id_pc !== RST_PC || id_instr !== mem_word(RST_PC)) begin
            failures++;
            $display("FAIL rm_head valid=%b pc=%h instr=%h expected 1/%h", id_valid, id_pc, id_instr, RST_PC);
        end
    endtask

    task automatic test_random();
        int accepted = 0;
        rand_lat = 1'b1; id_ready = 1'b1;
        reset_dut();
        for (int i = 0; i < 600; i++) begin
            tick();
            id_ready    = ($urandom_range(0, 3) != 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = $urandom;
            @(negedge clk);
            if (id_valid && id_ready && !redirect) accepted++;
        end
        tick();
        redirect = 1'b0;
        checks++;
        if (accepted < 50) begin
            failures++;
            $display("FAIL rand_progress accepted=%0d expected >= 50", accepted);
        end
    endtask

    initial begin
        test_reset();
        test_fetch_seq();
        test_backpressure();
        test_redirect_wait();
        test_redirect_rvalid();
        test_wrap();
        test_reset_midflight();
        test_random();
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage of the 5-stage RISC pipeline. It holds the fetch PC and issues one instruction-memory read at a time. Returned words are buffered with their PC in a small FIFO and presented to decode, where `id_instr` drives the `control_unit` instruction input. Decode backpressure stalls the stage, and branch redirects flush it.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch PC after reset.
- `FIFO_DEPTH`, default 2: instruction buffer entries; must be a power of 2 and at least 2.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_req`  out  1  one-cycle read request; accepted unconditionally by memory.
- `imem_addr`  out  32  read address; always equals the fetch PC register.
- `imem_rvalid`  in  1  read data valid; arrives at least 1 cycle after `imem_req`.
- `imem_rdata`  in  32  instruction word.
- `redirect`  in  1  branch taken; flush and restart fetch.
- `redirect_pc`  in  32  new fetch PC; bits [1:0] are ignored and forced to 00.
- `id_ready`  in  1  decode accepts the head instruction this cycle.
- `id_valid`  out  1  the head FIFO entry is valid.
- `id_instr`  out  32  head instruction; 0 when `id_valid`=0.
- `id_pc`  out  32  PC of the head instruction; 0 when `id_valid`=0.

## Operation
- States:
  - RUN: no request outstanding.
  - WAIT: one request outstanding, response will be kept.
  - DRAIN: one request outstanding, response will be dropped.
- Issue rule: `imem_req`=1 combinationally when state=RUN, `redirect`=0 and FIFO count < `FIFO_DEPTH`. On issue:
  - latch `pc_inflight` = fetch PC;
  - fetch PC += 4 (modulo 2^32, so 32'hFFFF_FFFC wraps to 0);
  - next state is WAIT.
- RUN, `imem_rvalid`=1: ignored (stale response, e.g. one in flight across a reset).
- WAIT, `imem_rvalid`=1, `redirect`=0: push {`pc_inflight`, `imem_rdata`}; next state is RUN.
- Redirect, any state:
  - fetch PC <= {`redirect_pc`[31:2], 2'b00};
  - FIFO cleared; a pop in the same cycle is ignored; no request that cycle.
  - Next state:
    - RUN -> RUN;
    - WAIT without rvalid -> DRAIN;
    - WAIT with rvalid -> RUN, data dropped;
    - DRAIN without rvalid -> DRAIN;
    - DRAIN with rvalid -> RUN, data dropped.
- DRAIN, `imem_rvalid`=1, `redirect`=0: data dropped; next state is RUN.
- FIFO:
  - Pop when `id_valid` && `id_ready`.
  - Push and pop in the same cycle are both performed; count is unchanged.
  - Push never occurs when full, because the issue rule reserves the slot.
- Reset values:
  - state = RUN;
  - fetch PC = `RESET_PC`, so `imem_addr` = `RESET_PC`;
  - FIFO empty, so `id_valid`, `id_instr` and `id_pc` are 0;
  - `pc_inflight` = 0.
- Reset asserted mid-operation: everything returns to the reset values immediately. Any pending response is discarded by the RUN ignore rule.

## Timing
- `imem_req` is asserted in the first cycle after `rst` deasserts.
- Fetch latency: `imem_rvalid` in cycle N gives `id_valid`=1 in cycle N+1 (registered FIFO).
- Peak throughput: 1 instruction per 2 cycles (request in cycle N, response in N+1, next request in N+2).
- Redirect in cycle N:
  - `id_valid`=0 in N+1;
  - first request to the new PC in N+1 if state was RUN, otherwise in the cycle after the dropped response.
- `id_instr`/`id_pc` are held stable while `id_valid`=1 and `id_ready`=0.
- No combinational path from `id_ready` to `imem_req`; the FIFO count used is the registered value.

## Structure
- `fetch_pkg` contains:
  - `fetch_state_e` enum {RUN, WAIT, DRAIN};
  - `fetch_entry_t` struct {pc[31:0], instr[31:0]};
  - `INSTR_BYTES` = 4;
  - `NOP_INSTR` = 32'h0000_0013, used for decode bubble insertion downstream.
- Sub-module `fetch_fifo`: parameterised depth over `fetch_entry_t`, with push, pop, clear, count, empty and full.
  - Storage and count reset asynchronously.
  - Clear has priority over push and pop.

## Test plan
- Reset, then memory returning data 1 cycle after each request, `id_ready`=1:
  - requests to 0x0, 0x4, 0x8 in cycles 0, 2, 4;
  - `id_pc` sequence 0x0, 0x4, 0x8 with the matching `id_instr`.
- `id_ready`=0 from reset:
  - exactly 2 requests issued, then `imem_req` stays 0;
  - head stays `id_pc`=0x0;
  - raising `id_ready` resumes requests at 0x8.
- `redirect`=1 with `redirect_pc`=0x103 while in WAIT:
  - the response is dropped and the FIFO is empty;
  - the next request goes to 0x100;
  - `id_pc`=0x100 appears next.
- `redirect` and `imem_rvalid` in the same WAIT cycle:
  - no push;
  - state becomes RUN;
  - next cycle `imem_req`=1 at `redirect_pc`.
- Redirect to 0xFFFF_FFFC:
  - requests go to 0xFFFF_FFFC then 0x0000_0000 (PC wraps).
- `rst` asserted while in WAIT, and `imem_rvalid` arrives after release:
  - the response is ignored;
  - `id_valid` stays 0 until the new request to `RESET_PC` returns.
